rv_decode_exec: RTL and testbench

//  RV32I single-cycle decode/execute slice: main control decoder, ALU-control decoder and ALU.

---
 rtl/rv_pkg.sv | 61 ++++++
 rtl/rv_alu_core.sv | 42 ++++
 rtl/rv_decode_exec.sv | 136 +++++++++++++
 tb/tb_rv_decode_exec.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I decode/execute slice.
// Contents: opcode constants, ALUOp encodings, 4-bit ALU operation codes,
// funct3 branch codes, the main-control bundle and its decoder function.
package rv_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00,
    ALUOP_SUB = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_I   = 2'b11
  } alu_op_e;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

  // Main control table; unknown opcodes produce an all-zero bundle.
  function automatic ctrl_t main_decode(input logic [6:0] opcode);
    case (opcode)
      OPC_R:      return '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_R};
      OPC_LOAD:   return '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALUOP_ADD};
      OPC_STORE:  return '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALUOP_ADD};
      OPC_BRANCH: return '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_SUB};
      OPC_IMM:    return '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_I};
      default:    return '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_ADD};
    endcase
  endfunction

endpackage

// File: rtl/rv_alu_core.sv
// Combinational ALU.
// Ports: a, b (XLEN operands), op (4-bit ALU code) -> result (XLEN), zero (result == 0).
// Shifts use the low $clog2(XLEN) bits of b; unknown op codes give 0.
module rv_alu_core
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  // NOTE: every combinational output is given a default before the case so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    result = '0;
    case (op)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $signed(a) >>> shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rv_decode_exec.sv
// RV32I decode/execute slice: main control, ALU control, ALU, branch decision.
// All outputs registered (one clock latency); synchronous active-low reset clears them.
// Ports: clock, reset, in_valid, instr, rs1_data, rs2_data, imm ->
//        out_valid, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
//        alu_op[1:0], alu_ctrl[3:0], alu_result, zero, branch_taken.
// Config: define BRANCH_EXT_EN for full funct3 branch conditions; otherwise every
//         branch uses BEQ semantics (taken when the SUB result is zero).
module rv_decode_exec
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  output logic            branch,
  output logic            mem_read,
  output logic            mem_to_reg,
  output logic            mem_write,
  output logic            alu_src,
  output logic            reg_write,
  output logic [1:0]      alu_op,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic            branch_taken
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign f7b5   = instr[30];
  // Register indices are decoded elsewhere in the pipeline.
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  ctrl_t ctrl;
  assign ctrl = main_decode(opcode);

  alu_ctrl_e alu_ctrl_n;

  always_comb begin
    alu_ctrl_n = ALU_ADD;
    case (ctrl.alu_op)
      ALUOP_ADD: alu_ctrl_n = ALU_ADD;
      ALUOP_SUB: alu_ctrl_n = ALU_SUB;
      default: begin
        case (funct3)
          // Immediate forms have imm bits in instr[30], so only R-type may select SUB.
          3'b000:  alu_ctrl_n = (ctrl.alu_op == ALUOP_R && f7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl_n = ALU_SLL;
          3'b010:  alu_ctrl_n = ALU_SLT;
          3'b011:  alu_ctrl_n = ALU_SLTU;
          3'b100:  alu_ctrl_n = ALU_XOR;
          3'b101:  alu_ctrl_n = f7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl_n = ALU_OR;
          default: alu_ctrl_n = ALU_AND;
        endcase
      end
    endcase
  end

  logic [XLEN-1:0] operand_b;
  logic [XLEN-1:0] result_n;
  logic            zero_n;

  assign operand_b = ctrl.alu_src ? imm : rs2_data;

  rv_alu_core #(.XLEN(XLEN)) u_alu (
    .a      (rs1_data),
    .b      (operand_b),
    .op     (alu_ctrl_n),
    .result (result_n),
    .zero   (zero_n)
  );

  logic cond;

`ifdef BRANCH_EXT_EN
  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = zero_n;
      F3_BNE:  cond = !zero_n;
      F3_BLT:  cond = $signed(rs1_data) <  $signed(rs2_data);
      F3_BGE:  cond = $signed(rs1_data) >= $signed(rs2_data);
      F3_BLTU: cond = rs1_data <  rs2_data;
      F3_BGEU: cond = rs1_data >= rs2_data;
      default: cond = 1'b0;
    endcase
  end
`else
  assign cond = zero_n;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; reset is sampled only at the clock edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      branch       <= 1'b0;
      mem_read     <= 1'b0;
      mem_to_reg   <= 1'b0;
      mem_write    <= 1'b0;
      alu_src      <= 1'b0;
      reg_write    <= 1'b0;
      alu_op       <= 2'b00;
      alu_ctrl     <= 4'b0000;
      alu_result   <= '0;
      zero         <= 1'b0;
      branch_taken <= 1'b0;
    end else begin
      out_valid    <= in_valid;
      branch       <= ctrl.branch;
      mem_read     <= ctrl.mem_read;
      mem_to_reg   <= ctrl.mem_to_reg;
      mem_write    <= ctrl.mem_write;
      alu_src      <= ctrl.alu_src;
      reg_write    <= ctrl.reg_write;
      alu_op       <= ctrl.alu_op;
      alu_ctrl     <= alu_ctrl_n;
      alu_result   <= result_n;
      zero         <= zero_n;
      branch_taken <= ctrl.branch & cond;
    end
  end

endmodule

// File: tb/tb_rv_decode_exec.sv
// Directed bench for rv_decode_exec: hand-computed vectors, one-cycle latency,
// reset behaviour, and branch conditions for either BRANCH_EXT_EN setting.
module tb_rv_decode_exec;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] F7_0   = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  // Expected flag bundle {branch,mem_read,mem_to_reg,mem_write,alu_src,reg_write,alu_op}
  localparam logic [7:0] FL_R   = 8'b0000_0110;
  localparam logic [7:0] FL_LD  = 8'b0110_1100;
  localparam logic [7:0] FL_ST  = 8'b0001_1000;
  localparam logic [7:0] FL_BR  = 8'b1000_0001;
  localparam logic [7:0] FL_I   = 8'b0000_1111;
  localparam logic [7:0] FL_NONE = 8'b0000_0000;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic [31:0]     instr = '0;
  logic [XLEN-1:0] rs1_data = '0;
  logic [XLEN-1:0] rs2_data = '0;
  logic [XLEN-1:0] imm = '0;

  logic            out_valid, branch, mem_read, mem_to_reg, mem_write;
  logic            alu_src, reg_write, zero, branch_taken;
  logic [1:0]      alu_op;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_result;

  int total = 0;
  int bad   = 0;

  rv_decode_exec #(.XLEN(XLEN)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .instr        (instr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .imm          (imm),
    .out_valid    (out_valid),
    .branch       (branch),
    .mem_read     (mem_read),
    .mem_to_reg   (mem_to_reg),
    .mem_write    (mem_write),
    .alu_src      (alu_src),
    .reg_write    (reg_write),
    .alu_op       (alu_op),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .zero         (zero),
    .branch_taken (branch_taken)
  );

  always #5 clock = ~clock;

  logic [7:0] flags;
  assign flags = {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  // Present inputs at the falling edge, let the rising edge load, sample 1 ns later.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] i);
    @(negedge clock);
    in_valid = v;
    instr    = ins;
    rs1_data = a;
    rs2_data = b;
    imm      = i;
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [7:0] f,
                            input logic [3:0] c, input logic [31:0] r,
                            input logic z, input logic t);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".flags"}, 32'(flags), 32'(f));
    check({tag, ".ctrl"},  32'(alu_ctrl), 32'(c));
    check({tag, ".res"},   alu_result, r);
    check({tag, ".zero"},  32'(zero), 32'(z));
    check({tag, ".taken"}, 32'(branch_taken), 32'(t));
  endtask

  task automatic expect_cleared(input string tag);
    check({tag, ".ctl"}, {19'd0, out_valid, flags, branch_taken, zero, alu_ctrl[3:2]},
          32'd0);
    check({tag, ".ctrl"}, 32'(alu_ctrl), 32'd0);
    check({tag, ".res"}, alu_result, 32'd0);
  endtask

  initial begin
    // Reset held with valid input: outputs must stay cleared.
    reset = 1'b0;
    drive(1'b1, enc(F7_0, 3'b000, OP_R), 32'd5, 32'd7, 32'd0);
    expect_cleared("reset");
    reset = 1'b1;

    drive(1'b1, enc(F7_0,   3'b000, OP_R), 32'd5, 32'd7, 32'd0);
    expect_out("add", 1, FL_R, 4'b0010, 32'd12, 0, 0);
    drive(1'b1, enc(F7_ALT, 3'b000, OP_R), 32'd9, 32'd9, 32'd0);
    expect_out("sub", 1, FL_R, 4'b0110, 32'd0, 1, 0);
    drive(1'b1, enc(F7_0,   3'b000, OP_R), 32'hFFFF_FFFF, 32'd1, 32'd0);
    expect_out("add_wrap", 1, FL_R, 4'b0010, 32'd0, 1, 0);
    drive(1'b1, enc(F7_0,   3'b010, OP_LD), 32'd100, 32'd55, 32'd8);
    expect_out("ld", 1, FL_LD, 4'b0010, 32'd108, 0, 0);
    drive(1'b1, enc(F7_0,   3'b010, OP_ST), 32'd100, 32'd55, 32'hFFFF_FFFC);
    expect_out("st", 1, FL_ST, 4'b0010, 32'd96, 0, 0);

    drive(1'b1, enc(F7_ALT, 3'b101, OP_R), 32'h8000_0000, 32'd4, 32'd0);
    expect_out("sra", 1, FL_R, 4'b0111, 32'hF800_0000, 0, 0);
    drive(1'b1, enc(F7_0,   3'b101, OP_R), 32'h8000_0000, 32'd4, 32'd0);
    expect_out("srl", 1, FL_R, 4'b0101, 32'h0800_0000, 0, 0);
    drive(1'b1, enc(F7_0,   3'b011, OP_R), 32'd1, 32'hFFFF_FFFF, 32'd0);
    expect_out("sltu", 1, FL_R, 4'b1001, 32'd1, 0, 0);
    drive(1'b1, enc(F7_0,   3'b010, OP_R), 32'd1, 32'hFFFF_FFFF, 32'd0);
    expect_out("slt", 1, FL_R, 4'b1000, 32'd0, 1, 0);
    drive(1'b1, enc(F7_0,   3'b001, OP_R), 32'd3, 32'd33, 32'd0);
    expect_out("sll_mask", 1, FL_R, 4'b0100, 32'd6, 0, 0);
    drive(1'b1, enc(F7_0,   3'b100, OP_R), 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0);
    expect_out("xor", 1, FL_R, 4'b0011, 32'hF0F0_F0F0, 0, 0);
    drive(1'b1, enc(F7_0,   3'b111, OP_R), 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0);
    expect_out("and", 1, FL_R, 4'b0000, 32'h0F00_0F00, 0, 0);

    // Immediate forms: instr[30] must not turn ADDI into SUB; SRAI honours it.
    drive(1'b1, enc(F7_ALT, 3'b000, OP_I), 32'd10, 32'd99, 32'hFFFF_FFFD);
    expect_out("addi", 1, FL_I, 4'b0010, 32'd7, 0, 0);
    drive(1'b1, enc(F7_ALT, 3'b101, OP_I), 32'h8000_0000, 32'd0, 32'h0000_0404);
    expect_out("srai", 1, FL_I, 4'b0111, 32'hF800_0000, 0, 0);

    drive(1'b1, enc(F7_0, 3'b000, OP_JAL), 32'd2, 32'd3, 32'd40);
    expect_out("unknown", 1, FL_NONE, 4'b0010, 32'd5, 0, 0);

    // Branches: SUB result drives zero; funct3 matters only with BRANCH_EXT_EN.
    drive(1'b1, enc(F7_0, 3'b000, OP_BR), 32'd3, 32'd3, 32'd0);
    expect_out("beq_t", 1, FL_BR, 4'b0110, 32'd0, 1, 1);
    drive(1'b1, enc(F7_0, 3'b000, OP_BR), 32'd3, 32'd4, 32'd0);
    expect_out("beq_nt", 1, FL_BR, 4'b0110, 32'hFFFF_FFFF, 0, 0);
`ifdef BRANCH_EXT_EN
    drive(1'b1, enc(F7_0, 3'b001, OP_BR), 32'd3, 32'd4, 32'd0);
    expect_out("bne", 1, FL_BR, 4'b0110, 32'hFFFF_FFFF, 0, 1);
    drive(1'b1, enc(F7_0, 3'b100, OP_BR), 32'hFFFF_FFFF, 32'd1, 32'd0);
    expect_out("blt", 1, FL_BR, 4'b0110, 32'hFFFF_FFFE, 0, 1);
    drive(1'b1, enc(F7_0, 3'b110, OP_BR), 32'hFFFF_FFFF, 32'd1, 32'd0);
    expect_out("bltu", 1, FL_BR, 4'b0110, 32'hFFFF_FFFE, 0, 0);
    drive(1'b1, enc(F7_0, 3'b100, OP_BR), 32'd7, 32'd7, 32'd0);
    expect_out("blt_eq", 1, FL_BR, 4'b0110, 32'd0, 1, 0);
    drive(1'b1, enc(F7_0, 3'b010, OP_BR), 32'd7, 32'd7, 32'd0);
    expect_out("br_f3_010", 1, FL_BR, 4'b0110, 32'd0, 1, 0);
`else
    drive(1'b1, enc(F7_0, 3'b001, OP_BR), 32'd3, 32'd4, 32'd0);
    expect_out("bne", 1, FL_BR, 4'b0110, 32'hFFFF_FFFF, 0, 0);
    drive(1'b1, enc(F7_0, 3'b100, OP_BR), 32'hFFFF_FFFF, 32'd1, 32'd0);
    expect_out("blt", 1, FL_BR, 4'b0110, 32'hFFFF_FFFE, 0, 0);
    drive(1'b1, enc(F7_0, 3'b100, OP_BR), 32'd7, 32'd7, 32'd0);
    expect_out("blt_eq", 1, FL_BR, 4'b0110, 32'd0, 1, 1);
    drive(1'b1, enc(F7_0, 3'b010, OP_BR), 32'd7, 32'd7, 32'd0);
    expect_out("br_f3_010", 1, FL_BR, 4'b0110, 32'd0, 1, 1);
`endif

    // in_valid low: out_valid drops but the datapath still loads.
    drive(1'b0, enc(F7_0, 3'b110, OP_R), 32'h0000_00F0, 32'h0000_000F, 32'd0);
    expect_out("inval", 0, FL_R, 4'b0001, 32'h0000_00FF, 0, 0);

    // Mid-stream reset with valid input, then recovery on the next edge.
    drive(1'b1, enc(F7_0, 3'b000, OP_R), 32'd20, 32'd22, 32'd0);
    expect_out("pre_rst", 1, FL_R, 4'b0010, 32'd42, 0, 0);
    reset = 1'b0;
    drive(1'b1, enc(F7_0, 3'b000, OP_LD), 32'd100, 32'd0, 32'd8);
    expect_cleared("mid_rst");
    reset = 1'b1;
    drive(1'b1, enc(F7_0, 3'b000, OP_LD), 32'd100, 32'd0, 32'd8);
    expect_out("post_rst", 1, FL_LD, 4'b0010, 32'd108, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
